// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and selectable registered or first-word-fall-through read.
module fifo_sync_param #(
  parameter int MEMORY_WIDTH    = 8,
  parameter int ADDRESS_SIZE    = 4,
  parameter int ALMOST_FULL_TH  = 12,
  parameter int ALMOST_EMPTY_TH = 2,
  parameter bit FWFT            = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    w_en,
  input  logic [MEMORY_WIDTH-1:0] wdata,
  input  logic                    r_en,
  output logic [MEMORY_WIDTH-1:0] rdata,
  output logic                    w_full,
  output logic                    r_empty,
  output logic                    w_almost_full,
  output logic                    r_almost_empty,
  output logic [ADDRESS_SIZE:0]   count,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    err_clr
);

  localparam int MEMORY_DEPTH = 2 ** ADDRESS_SIZE;
  localparam logic [ADDRESS_SIZE:0] AF_TH   = (ADDRESS_SIZE+1)'(ALMOST_FULL_TH);
  localparam logic [ADDRESS_SIZE:0] AE_TH   = (ADDRESS_SIZE+1)'(ALMOST_EMPTY_TH);
  localparam logic [ADDRESS_SIZE:0] PTR_ONE = (ADDRESS_SIZE+1)'(1);

  logic [MEMORY_WIDTH-1:0] mem [MEMORY_DEPTH];
  logic [ADDRESS_SIZE:0]   w_ptr;
  logic [ADDRESS_SIZE:0]   r_ptr;
  logic [ADDRESS_SIZE-1:0] w_addr;
  logic [ADDRESS_SIZE-1:0] r_addr;
  logic                    cw_en;
  logic                    cr_en;

  assign w_addr = w_ptr[ADDRESS_SIZE-1:0];
  assign r_addr = r_ptr[ADDRESS_SIZE-1:0];

  // The extra pointer MSB distinguishes a full wrap from an empty FIFO.
  assign r_empty        = (w_ptr == r_ptr);
  assign w_full         = (w_ptr[ADDRESS_SIZE] != r_ptr[ADDRESS_SIZE]) && (w_addr == r_addr);
  assign w_almost_full  = (count >= AF_TH);
  assign r_almost_empty = (count <= AE_TH);

  assign cw_en = w_en && !w_full;
  assign cr_en = r_en && !r_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (cw_en) w_ptr <= w_ptr + PTR_ONE;
      if (cr_en) r_ptr <= r_ptr + PTR_ONE;

      case ({cw_en, cr_en})
        2'b10:   count <= count + PTR_ONE;
        2'b01:   count <= count - PTR_ONE;
        default: count <= count;
      endcase

      // A new error event in the same cycle as a clear keeps the flag set.
      if (w_en && w_full)  overflow <= 1'b1;
      else if (err_clr)    overflow <= 1'b0;

      if (r_en && r_empty) underflow <= 1'b1;
      else if (err_clr)    underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && cw_en) mem[w_addr] <= wdata;
  end

  generate
    if (FWFT) begin : g_fwft
      assign rdata = mem[r_addr];
    end else begin : g_std
      always_ff @(posedge clk) begin
        if (!rst_n)     rdata <= '0;
        else if (cr_en) rdata <= mem[r_addr];
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a queue model checks a standard-read and an FWFT
// instance every cycle, plus hand-computed literal checks along a directed sequence.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       w_en = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       r_en = 1'b0;
  logic       err_clr = 1'b0;

  logic [7:0] rdata0, rdata1;
  logic       w_full0, r_empty0, af0, ae0, ovf0, udf0;
  logic       w_full1, r_empty1, af1, ae1, ovf1, udf1;
  logic [4:0] count0, count1;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mq[$];
  logic [7:0] m_rd0 = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  bit         model_valid = 1'b0;

  always #5 clk = ~clk;

  fifo_sync_param #(.FWFT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .wdata(wdata), .r_en(r_en),
    .rdata(rdata0), .w_full(w_full0), .r_empty(r_empty0), .w_almost_full(af0),
    .r_almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(udf0),
    .err_clr(err_clr)
  );

  fifo_sync_param #(.FWFT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .wdata(wdata), .r_en(r_en),
    .rdata(rdata1), .w_full(w_full1), .r_empty(r_empty1), .w_almost_full(af1),
    .r_almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(udf1),
    .err_clr(err_clr)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain queue of 16 entries updated on each rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_rd0 = 8'h00;
      m_ovf = 1'b0;
      m_udf = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      bit full, empty;
      full  = (mq.size() == 16);
      empty = (mq.size() == 0);
      if (w_en && full)       m_ovf = 1'b1;
      else if (err_clr)       m_ovf = 1'b0;
      if (r_en && empty)      m_udf = 1'b1;
      else if (err_clr)       m_udf = 1'b0;
      if (r_en && !empty)     m_rd0 = mq.pop_front();
      if (w_en && !full)      mq.push_back(wdata);
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      int sz;
      sz = mq.size();
      checkOutput("count0",   32'(count0),   32'(sz));
      checkOutput("w_full0",  32'(w_full0),  32'(sz == 16));
      checkOutput("r_empty0", 32'(r_empty0), 32'(sz == 0));
      checkOutput("af0",      32'(af0),      32'(sz >= 12));
      checkOutput("ae0",      32'(ae0),      32'(sz <= 2));
      checkOutput("ovf0",     32'(ovf0),     32'(m_ovf));
      checkOutput("udf0",     32'(udf0),     32'(m_udf));
      checkOutput("rdata0",   32'(rdata0),   32'(m_rd0));
      checkOutput("count1",   32'(count1),   32'(sz));
      checkOutput("w_full1",  32'(w_full1),  32'(sz == 16));
      checkOutput("r_empty1", 32'(r_empty1), 32'(sz == 0));
      checkOutput("af1",      32'(af1),      32'(sz >= 12));
      checkOutput("ae1",      32'(ae1),      32'(sz <= 2));
      checkOutput("ovf1",     32'(ovf1),     32'(m_ovf));
      checkOutput("udf1",     32'(udf1),     32'(m_udf));
      if (sz > 0) checkOutput("rdata1", 32'(rdata1), 32'(mq[0]));
    end
  end

  // Drive one cycle of inputs, let the edge sample them, return just after it.
  task automatic applyStimulus(input logic we, input logic [7:0] wd, input logic re, input logic clr);
    w_en = we; wdata = wd; r_en = re; err_clr = clr;
    @(posedge clk);
    #1;
    w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_count"},   32'(count0),   32'd0);
    checkOutput({tag, "_empty"},   32'(r_empty0), 32'd1);
    checkOutput({tag, "_full"},    32'(w_full0),  32'd0);
    checkOutput({tag, "_ae"},      32'(ae0),      32'd1);
    checkOutput({tag, "_af"},      32'(af0),      32'd0);
    checkOutput({tag, "_ovf"},     32'(ovf0),     32'd0);
    checkOutput({tag, "_udf"},     32'(udf0),     32'd0);
    checkOutput({tag, "_rdata"},   32'(rdata0),   32'd0);
    checkOutput({tag, "_count1"},  32'(count1),   32'd0);
    checkOutput({tag, "_model"},   32'(mq.size()), 32'd0);
  endtask

  initial begin
    #2;
    doReset();
    checkResetState("rst");

    // Fill to full, watching the threshold crossings.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 1)  checkOutput("ae_at2",  32'(ae0), 32'd1);
      if (i == 2)  checkOutput("ae_at3",  32'(ae0), 32'd0);
      if (i == 10) checkOutput("af_at11", 32'(af0), 32'd0);
      if (i == 11) checkOutput("af_at12", 32'(af0), 32'd1);
    end
    checkOutput("full_at16",  32'(w_full0),   32'd1);
    checkOutput("count_16",   32'(count0),    32'd16);
    checkOutput("model_16",   32'(mq.size()), 32'd16);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
    checkOutput("ovf_set",    32'(ovf0),      32'd1);
    checkOutput("count_hold", 32'(count0),    32'd16);

    // Drain in order with one-cycle read latency.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("drain_rdata", 32'(rdata0), 32'(i));
    end
    checkOutput("empty_after", 32'(r_empty0), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("udf_set",    32'(udf0),   32'd1);
    checkOutput("rdata_hold", 32'(rdata0), 32'h0F);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("clr_ovf", 32'(ovf0), 32'd0);
    checkOutput("clr_udf", 32'(udf0), 32'd0);

    // Forty writes interleaved with reads around count 8, wrapping the pointers.
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 8'(8'h20 + k), 1'b0, 1'b0);
    for (int k = 8; k < 40; k++) begin
      applyStimulus(1'b1, 8'(8'h20 + k), 1'b0, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("wrap_last",  32'(rdata0),   32'h47);
    checkOutput("wrap_empty", 32'(r_empty0), 32'd1);

    // Simultaneous read and write when empty, full, and mid-level.
    applyStimulus(1'b1, 8'h51, 1'b1, 1'b0);
    checkOutput("sim_empty_count", 32'(count0), 32'd1);
    checkOutput("sim_empty_udf",   32'(udf0),   32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    checkOutput("sim_full_pre", 32'(w_full0), 32'd1);
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b0);
    checkOutput("sim_full_count", 32'(count0), 32'd15);
    checkOutput("sim_full_ovf",   32'(ovf0),   32'd1);
    checkOutput("sim_full_rdata", 32'(rdata0), 32'h51);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("mid_rdata", 32'(rdata0), 32'h69);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    checkOutput("sim_mid_count", 32'(count0), 32'd5);
    checkOutput("sim_mid_rdata", 32'(rdata0), 32'h6A);
    checkOutput("sim_mid_flags", 32'({ovf0, udf0}), 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("sim_drain_last", 32'(rdata0), 32'h77);

    // First-word-fall-through instance shows the head word without a read.
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    checkOutput("fwft_empty", 32'(r_empty1), 32'd0);
    checkOutput("fwft_rdata", 32'(rdata1),   32'hA5);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("fwft_hold",  32'(rdata1),   32'hA5);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("fwft_read_empty", 32'(r_empty1), 32'd1);
    checkOutput("std_read_a5",     32'(rdata0),   32'hA5);

    // Mid-operation reset, then clear racing a new overflow.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    checkOutput("pre_rst_count", 32'(count0), 32'd7);
    doReset();
    checkResetState("midrst");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1);
    checkOutput("set_wins_ovf",   32'(ovf0),   32'd1);
    checkOutput("set_wins_count", 32'(count0), 32'd16);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("clr_after", 32'(ovf0), 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
